// File: rtl/sym2_word_decoder.sv
// Receive-side 2-bit symbol decoder: undoes the complement coding and packs
// NSYM decoded symbols into one word behind a one-entry registered output.

module sym2_dec (
  input  logic [1:0] sym_i,
  output logic [1:0] dat_o
);
  always_comb begin
    unique case (sym_i)
      2'd0: dat_o = 2'd3;
      2'd1: dat_o = 2'd2;
      2'd2: dat_o = 2'd1;
      2'd3: dat_o = 2'd0;
    endcase
  end
endmodule

module sym2_word_decoder #(
  parameter int NSYM      = 4,
  parameter bit MSB_FIRST = 1'b1,
  localparam int W        = 2 * NSYM
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [1:0]   in_sym_i,
  input  logic         in_sop_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic         sync_err_o
);
  localparam int CW = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSYM - 1);

  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  logic [1:0]    dec;
  logic [W-1:0]  shifted, fresh;
  logic          accept, last;

  sym2_dec u_dec (.sym_i(in_sym_i), .dat_o(dec));

  // A symbol that would complete a word may only enter when the output
  // register is free or draining in the same cycle.
  assign last       = (count_q == LAST);
  assign in_ready_o = !rst_i && (!valid_q || out_ready_i || !last);
  assign accept     = in_valid_i && in_ready_o;

  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {acc_q[W-3:0], dec};
      assign fresh   = {{(W-2){1'b0}}, dec};
    end else begin : g_lsb
      assign shifted = {dec, acc_q[W-1:2]};
      assign fresh   = {dec, {(W-2){1'b0}}};
    end
  endgenerate

  always_comb begin
    count_d = count_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    if (valid_q && out_ready_i) valid_d = 1'b0;
    if (accept) begin
      if (in_sop_i) begin
        // Start-of-word resync: anything partial is dropped.
        acc_d   = fresh;
        count_d = CW'(1);
        err_d   = (count_q != '0);
      end else if (last) begin
        acc_d   = shifted;
        data_d  = shifted;
        valid_d = 1'b1;
        count_d = '0;
      end else begin
        acc_d   = shifted;
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign sync_err_o  = err_q;
endmodule

// File: tb/tb_sym2_word_decoder.sv
// Directed + random bench for sym2_word_decoder; runs MSB-first and
// LSB-first instances side by side against a symbol-queue reference model.

module tb_sym2_word_decoder;
  localparam int NSYM = 4;
  localparam int W    = 2 * NSYM;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_sop = 1'b0, out_ready = 1'b0;
  logic [1:0] in_sym = 2'd0;

  logic         m_rdy, m_ov, m_err, l_rdy, l_ov, l_err;
  logic [W-1:0] m_data, l_data;

  always #5 clk = ~clk;

  sym2_word_decoder #(.NSYM(NSYM), .MSB_FIRST(1'b1)) u_msb (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(m_rdy),
    .in_sym_i(in_sym), .in_sop_i(in_sop), .out_valid_o(m_ov),
    .out_ready_i(out_ready), .out_data_o(m_data), .sync_err_o(m_err));

  sym2_word_decoder #(.NSYM(NSYM), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(l_rdy),
    .in_sym_i(in_sym), .in_sop_i(in_sop), .out_valid_o(l_ov),
    .out_ready_i(out_ready), .out_data_o(l_data), .sync_err_o(l_err));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: decoded symbols of the word in progress, and words
  // completed but not yet taken by the consumer (in both packing orders).
  logic [1:0]   part[$];
  logic [W-1:0] wq_m[$];
  logic [W-1:0] wq_l[$];
  logic         exp_err = 1'b0;
  int           accepted = 0, model_words = 0, dut_words = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    part.delete();
    wq_m.delete();
    wq_l.delete();
    exp_err = 1'b0;
  endtask

  // One clock cycle: drive inputs on the falling edge, check outputs against
  // the model, then advance the model by what the rising edge will do.
  task automatic cyc(input logic v, input logic [1:0] s, input logic sop, input logic ordy);
    logic [W-1:0] wm, wl;
    logic         exp_rdy;
    @(negedge clk);
    in_valid = v; in_sym = s; in_sop = sop; out_ready = ordy;
    #1;
    exp_rdy = !(wq_m.size() != 0 && !ordy && part.size() == NSYM - 1);
    chk("sync_err",  {m_err, l_err}, {exp_err, exp_err});
    chk("out_valid", {m_ov, l_ov},   {2{wq_m.size() != 0}});
    chk("in_ready",  {m_rdy, l_rdy}, {exp_rdy, exp_rdy});
    if (m_ov && ordy) begin
      dut_words++;
      if (wq_m.size() != 0) begin
        chk("word_msb", 32'(m_data), 32'(wq_m[0]));
        chk("word_lsb", 32'(l_data), 32'(wq_l[0]));
        void'(wq_m.pop_front());
        void'(wq_l.pop_front());
      end
    end
    exp_err = 1'b0;
    if (v && m_rdy) begin
      accepted++;
      if (sop && part.size() != 0) begin
        exp_err = 1'b1;
        part.delete();
      end
      part.push_back(~s);
      if (part.size() == NSYM) begin
        wm = '0; wl = '0;
        for (int i = 0; i < NSYM; i++) begin
          wm = wm | (W'(part[i]) << (2 * (NSYM - 1 - i)));
          wl = wl | (W'(part[i]) << (2 * i));
        end
        wq_m.push_back(wm);
        wq_l.push_back(wl);
        model_words++;
        part.delete();
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_sop = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", {m_rdy, l_rdy}, 2'b00);
    model_clear();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    int cycles;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready0", {m_rdy, l_rdy}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {m_ov, l_ov}, 2'b00);
    chk("rst_out_data",  32'({m_data, l_data}), 32'h0);
    chk("rst_sync_err",  {m_err, l_err}, 2'b00);

    // Basic word: 3,2,1,0
    cyc(1, 2'd3, 0, 1); cyc(1, 2'd2, 0, 1); cyc(1, 2'd1, 0, 1); cyc(1, 2'd0, 0, 1);
    cyc(0, 2'd0, 0, 1);
    chk("basic_valid", {m_ov, l_ov}, 2'b11);
    chk("basic_msb", 32'(m_data), 32'h1B);
    chk("basic_lsb", 32'(l_data), 32'hE4);
    cyc(0, 2'd0, 0, 1);
    chk("basic_drop", {m_ov, l_ov}, 2'b00);

    // Backpressure: 8 zero symbols with the consumer stalled
    for (int i = 0; i < 7; i++) cyc(1, 2'd0, 0, 0);
    cyc(1, 2'd0, 0, 0);
    chk("bp_stall_rdy", {m_rdy, l_rdy}, 2'b00);
    chk("bp_hold_msb", 32'(m_data), 32'hFF);
    cyc(1, 2'd0, 0, 0);
    chk("bp_hold_lsb", 32'(l_data), 32'hFF);
    cyc(1, 2'd0, 0, 1);
    chk("bp_drain_rdy", {m_rdy, l_rdy}, 2'b11);
    cyc(0, 2'd0, 0, 0);
    chk("bp_nobubble", {m_ov, l_ov}, 2'b11);
    chk("bp_second", 32'({m_data, l_data}), 32'hFFFF);
    cyc(0, 2'd0, 0, 1);

    // Resync: 0,0 then sop 3, then 3,3,3
    cyc(1, 2'd0, 0, 1); cyc(1, 2'd0, 0, 1); cyc(1, 2'd3, 1, 1);
    cyc(1, 2'd3, 0, 1);
    chk("sop_err", {m_err, l_err}, 2'b11);
    cyc(1, 2'd3, 0, 1);
    chk("sop_err_once", {m_err, l_err}, 2'b00);
    cyc(1, 2'd3, 0, 1);
    cyc(0, 2'd0, 0, 1);
    chk("sop_word", {m_ov, l_ov, 8'(m_data), 8'(l_data)}, 18'h30000);
    cyc(0, 2'd0, 0, 1);

    // Reset mid-word
    cyc(1, 2'd2, 0, 1); cyc(1, 2'd2, 0, 1);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 2'd1, 0, 1);
    cyc(0, 2'd0, 0, 1);
    chk("rst_word", 32'({m_data, l_data}), 32'hAAAA);
    cyc(0, 2'd0, 0, 1);

    // Random traffic
    accepted = 0; model_words = 0; dut_words = 0; cycles = 0;
    while (accepted < 1000 && cycles < 20000) begin
      cyc(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 99) < 3), ($urandom_range(0, 9) < 6));
      cycles++;
    end
    chk("rand_timeout", 32'(accepted >= 1000), 32'd1);
    for (int i = 0; i < 4; i++) cyc(0, 2'd0, 0, 1);
    chk("rand_word_count", 32'(dut_words), 32'(model_words));
    chk("rand_drained", 32'(wq_m.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
